// File: rtl/reaction_pkg.sv
// rtl/reaction_pkg.sv - shared types and constants for the reaction-timer sequencer
// Contents: bcd_t, dst_t status codes, state_t round states, BCD_MAX,
// LFSR_TAPS, lfsr_next() and dst_of() helpers.
package reaction_pkg;

    typedef logic [23:0] bcd_t;

    typedef enum logic [2:0] {
        DST_IDLE  = 3'b000,
        DST_READY = 3'b001,
        DST_GO    = 3'b010,
        DST_MISS  = 3'b011,
        DST_HIT   = 3'b110
    } dst_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_GO,
        ST_MISS,
        ST_HIT
    } state_t;

    localparam bcd_t BCD_MAX = 24'h999999;

    // Taps 16,14,13,11 expressed as bit positions 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

    function automatic dst_t dst_of(input state_t s);
        case (s)
            ST_WAIT: return DST_READY;
            ST_GO:   return DST_GO;
            ST_MISS: return DST_MISS;
            ST_HIT:  return DST_HIT;
            default: return DST_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/bcd_counter6.sv
// rtl/bcd_counter6.sv - six-digit BCD up-counter with clear and overflow flag
// Ports: clk, rst_n (async active-low), clear (sync, dominant), enable
// (count one step), value (current count), overflow (value==999999 && enable).
module bcd_counter6
    import reaction_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output bcd_t value,
    output logic overflow
);

    bcd_t       value_q;
    bcd_t       value_d;
    logic [6:0] carry;

    always_comb begin
        value_d  = value_q;
        carry    = '0;
        carry[0] = enable;
        // Ripple the increment up through the digits; a digit at 9 wraps to 0
        // and passes the carry on.
        for (int i = 0; i < 6; i++) begin
            if (carry[i]) begin
                if (value_q[4*i +: 4] == 4'd9) begin
                    value_d[4*i +: 4] = 4'd0;
                    carry[i+1]        = 1'b1;
                end else begin
                    value_d[4*i +: 4] = value_q[4*i +: 4] + 4'd1;
                end
            end
        end
        if (clear) begin
            value_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value    = value_q;
    assign overflow = enable && (value_q == BCD_MAX);

endmodule

// File: rtl/reaction_ctrl.sv
// rtl/reaction_ctrl.sv - reaction-timer round sequencer, delay generator and result tracker
// Ports: i_clk, i_rst_n (async active-low), i_btn (debounced button level),
// i_bcdmux (0 last / 1 best on o_bcd), o_dst (status code), o_lit (GO),
// o_miss (MISS), o_init (no hit yet), o_bcd, o_last, o_best (BCD ms.us).
module reaction_ctrl
    import reaction_pkg::*;
#(
    parameter int          CLK_HZ       = 25_000_000,
    parameter int          MIN_DELAY_MS = 1000,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_btn,
    input  logic        i_bcdmux,
    output logic [2:0]  o_dst,
    output logic        o_lit,
    output logic        o_miss,
    output logic        o_init,
    output logic [23:0] o_bcd,
    output logic [23:0] o_last,
    output logic [23:0] o_best
);

    localparam int PRE_MAX = CLK_HZ / 1_000_000 - 1;
    localparam int PRE_W   = (PRE_MAX > 0) ? $clog2(PRE_MAX + 1) : 1;

    state_t           state_q, state_d;
    logic             btn_q, btn_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [15:0]      lfsr_q, lfsr_d;
    logic [9:0]       ms_cnt_q, ms_cnt_d;
    logic [11:0]      dly_cnt_q, dly_cnt_d;
    logic [11:0]      delay_q, delay_d;
    bcd_t             last_q, last_d;
    bcd_t             best_q, best_d;
    logic             init_q, init_d;
    dst_t             dst_q, dst_d;
    logic             lit_q, lit_d;
    logic             miss_q, miss_d;

    logic press;
    logic running;
    logic us_tick;
    logic ms_tick;
    logic expire;
    logic entry;
    logic tmr_clr;
    logic tmr_en;
    logic tmr_ovf;
    bcd_t tmr;

    assign press   = i_btn & ~btn_q;
    assign running = (state_q == ST_WAIT) || (state_q == ST_GO);
    assign us_tick = running && (pre_q == PRE_W'(PRE_MAX));
    assign ms_tick = (state_q == ST_WAIT) && us_tick && (ms_cnt_q == 10'd999);
    // Expiry fires on the ms_tick that brings the count up to the delay.
    assign expire  = ms_tick && ((dly_cnt_q + 12'd1) == delay_q);

    assign tmr_clr = entry && (state_d == ST_GO);
    assign tmr_en  = us_tick && (state_q == ST_GO);

    bcd_counter6 u_timer (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .clear    (tmr_clr),
        .enable   (tmr_en),
        .value    (tmr),
        .overflow (tmr_ovf)
    );

    // Round state and result capture. A press always takes priority over a
    // same-cycle delay expiry or timer overflow.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        best_d  = best_q;
        init_d  = init_q;
        case (state_q)
            ST_IDLE: begin
                if (press) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (press)       state_d = ST_MISS;
                else if (expire) state_d = ST_GO;
            end
            ST_GO: begin
                if (press) begin
                    state_d = ST_HIT;
                    last_d  = tmr;
                    if (init_q || (tmr < best_q)) begin
                        best_d = tmr;
                        init_d = 1'b0;
                    end
                end else if (tmr_ovf) begin
                    state_d = ST_MISS;
                end
            end
            ST_MISS, ST_HIT: begin
                if (press) state_d = ST_WAIT;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign entry = (state_d != state_q);

    always_comb begin
        btn_d  = i_btn;
        lfsr_d = lfsr_next(lfsr_q);

        if (entry || !running || us_tick) pre_d = '0;
        else                              pre_d = pre_q + PRE_W'(1);

        ms_cnt_d = ms_cnt_q;
        if (entry)                                  ms_cnt_d = '0;
        else if ((state_q == ST_WAIT) && us_tick)   ms_cnt_d = ms_tick ? 10'd0 : ms_cnt_q + 10'd1;

        dly_cnt_d = dly_cnt_q;
        if (entry)        dly_cnt_d = '0;
        else if (ms_tick) dly_cnt_d = dly_cnt_q + 12'd1;

        delay_d = delay_q;
        if (entry && (state_d == ST_WAIT)) begin
            delay_d = 12'(MIN_DELAY_MS) + {1'b0, lfsr_q[10:0]};
        end

        // Status outputs follow the next state so they change on the same
        // edge as the state register.
        dst_d  = dst_of(state_d);
        lit_d  = (state_d == ST_GO);
        miss_d = (state_d == ST_MISS);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            btn_q     <= 1'b1;
            pre_q     <= '0;
            lfsr_q    <= LFSR_SEED;
            ms_cnt_q  <= '0;
            dly_cnt_q <= '0;
            delay_q   <= '0;
            last_q    <= '0;
            best_q    <= '0;
            init_q    <= 1'b1;
            dst_q     <= DST_IDLE;
            lit_q     <= 1'b0;
            miss_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            btn_q     <= btn_d;
            pre_q     <= pre_d;
            lfsr_q    <= lfsr_d;
            ms_cnt_q  <= ms_cnt_d;
            dly_cnt_q <= dly_cnt_d;
            delay_q   <= delay_d;
            last_q    <= last_d;
            best_q    <= best_d;
            init_q    <= init_d;
            dst_q     <= dst_d;
            lit_q     <= lit_d;
            miss_q    <= miss_d;
        end
    end

    assign o_dst  = dst_q;
    assign o_lit  = lit_q;
    assign o_miss = miss_q;
    assign o_init = init_q;
    assign o_last = last_q;
    assign o_best = best_q;
    assign o_bcd  = i_bcdmux ? best_q : last_q;

endmodule

// File: tb/tb_reaction_ctrl.sv
// tb/tb_reaction_ctrl.sv - scoreboard bench for reaction_ctrl
module tb_reaction_ctrl;

    localparam logic [2:0] D_IDLE  = 3'b000;
    localparam logic [2:0] D_READY = 3'b001;
    localparam logic [2:0] D_GO    = 3'b010;
    localparam logic [2:0] D_MISS  = 3'b011;
    localparam logic [2:0] D_HIT   = 3'b110;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        btn    = 1'b1;
    logic        bcdmux = 1'b0;
    logic [2:0]  dst;
    logic        lit;
    logic        miss;
    logic        init;
    logic [23:0] bcd;
    logic [23:0] last;
    logic [23:0] best;

    reaction_ctrl #(
        .CLK_HZ       (2_000_000),
        .MIN_DELAY_MS (1),
        .LFSR_SEED    (16'h0001)
    ) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_btn    (btn),
        .i_bcdmux (bcdmux),
        .o_dst    (dst),
        .o_lit    (lit),
        .o_miss   (miss),
        .o_init   (init),
        .o_bcd    (bcd),
        .o_last   (last),
        .o_best   (best)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference LFSR: shift left, feedback from taps 16,14,13,11.
    logic [15:0] m_lfsr;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= 16'h0001;
        else        m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    typedef struct {
        string       name;
        logic [2:0]  dst;
        logic        lit;
        logic        miss;
        logic        init;
        logic [23:0] last;
        logic [23:0] best;
        int          cyc;
    } exp_t;

    exp_t        sbq[$];
    logic [23:0] exp_last = '0;
    logic [23:0] exp_best = '0;
    logic        exp_init = 1'b1;

    task automatic push(input string name, input logic [2:0] d, input int c);
        exp_t e;
        e.name = name;
        e.dst  = d;
        e.lit  = (d == D_GO);
        e.miss = (d == D_MISS);
        e.init = exp_init;
        e.last = exp_last;
        e.best = exp_best;
        e.cyc  = c;
        sbq.push_back(e);
    endtask

    // Monitor: every status change is matched against the next expected event.
    logic [2:0] prev_dst = 3'b000;
    exp_t       mon_e;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_dst <= D_IDLE;
        end else if (dst !== prev_dst) begin
            prev_dst <= dst;
            if (sbq.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_transition: o_dst=%b at cycle %0d, none expected", dst, cyc);
            end else begin
                mon_e = sbq.pop_front();
                chk({mon_e.name, "_dst"},  64'(dst),  64'(mon_e.dst));
                chk({mon_e.name, "_cyc"},  64'(cyc),  64'(mon_e.cyc));
                chk({mon_e.name, "_lit"},  64'(lit),  64'(mon_e.lit));
                chk({mon_e.name, "_miss"}, 64'(miss), 64'(mon_e.miss));
                chk({mon_e.name, "_init"}, 64'(init), 64'(mon_e.init));
                chk({mon_e.name, "_last"}, 64'(last), 64'(mon_e.last));
                chk({mon_e.name, "_best"}, 64'(best), 64'(mon_e.best));
            end
        end
    end

    // Called at a negedge: press is sampled on the next posedge, then the
    // button is released and held low across one more edge.
    task automatic press_btn();
        btn = 1'b1;
        @(negedge clk);
        btn = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_dst(input string name, input logic [2:0] d, input int budget);
        int k = 0;
        while (dst !== d && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk({name, "_reach"}, 64'(dst), 64'(d));
    endtask

    // Press into WAIT when the reference LFSR gives a short delay, then run to GO.
    task automatic start_round(input string name);
        int k = 0;
        int d;
        int press_at;
        while (m_lfsr[10:0] > 11'd1 && k < 10000) begin
            @(negedge clk);
            k++;
        end
        d        = 1 + int'(m_lfsr[10:0]);
        press_at = cyc + 1;
        push({name, "_wait"}, D_READY, press_at);
        push({name, "_go"},   D_GO,    press_at + 2000 * d);
        press_btn();
        wait_dst(name, D_GO, 2000 * d + 10);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: no summary after %0d cycles", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with the button held; no edge may come out of reset.
        repeat (3) @(negedge clk);
        chk("rst_dst",  64'(dst),  64'(D_IDLE));
        chk("rst_lit",  64'(lit),  64'd0);
        chk("rst_miss", 64'(miss), 64'd0);
        chk("rst_init", 64'(init), 64'd1);
        chk("rst_bcd",  64'(bcd),  64'd0);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        chk("held_btn_dst", 64'(dst), 64'(D_IDLE));
        btn = 1'b0;
        @(negedge clk);

        // First hit at 345 us sets both last and best.
        start_round("r1");
        repeat (690) @(negedge clk);
        exp_last = 24'h000345;
        exp_best = 24'h000345;
        exp_init = 1'b0;
        push("r1_hit", D_HIT, cyc + 1);
        press_btn();

        // Slower hit at 512 us: last updates, best holds.
        start_round("r2");
        repeat (1024) @(negedge clk);
        exp_last = 24'h000512;
        push("r2_hit", D_HIT, cyc + 1);
        press_btn();
        bcdmux = 1'b0;
        #1 chk("bcdmux_last", 64'(bcd), 64'h000512);
        bcdmux = 1'b1;
        #1 chk("bcdmux_best", 64'(bcd), 64'h000345);
        bcdmux = 1'b0;

        // Early press in WAIT gives MISS; another press rearms.
        push("r3_wait", D_READY, cyc + 1);
        press_btn();
        repeat (50) @(negedge clk);
        push("r3_early", D_MISS, cyc + 1);
        press_btn();

        // Timer overflow without a press: preload the timer to 999990 on a
        // non-tick edge, ten ticks later the wrap lands on edge G0+20.
        start_round("r4");
        force dut.u_timer.value_q = 24'h999990;
        @(negedge clk);
        release dut.u_timer.value_q;
        push("r4_ovf", D_MISS, cyc + 19);
        wait_dst("r4_ovf", D_MISS, 40);

        // Press on the overflow edge wins and captures 999999.
        start_round("r5");
        force dut.u_timer.value_q = 24'h999990;
        @(negedge clk);
        release dut.u_timer.value_q;
        repeat (18) @(negedge clk);
        exp_last = 24'h999999;
        push("r5_hit", D_HIT, cyc + 1);
        press_btn();

        // Asynchronous reset mid-GO, then the first hit must set best.
        start_round("r6");
        repeat (50) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_dst",  64'(dst),  64'(D_IDLE));
        chk("arst_lit",  64'(lit),  64'd0);
        chk("arst_miss", 64'(miss), 64'd0);
        chk("arst_init", 64'(init), 64'd1);
        chk("arst_last", 64'(last), 64'd0);
        chk("arst_best", 64'(best), 64'd0);
        chk("arst_queue_empty", 64'(sbq.size()), 64'd0);
        exp_last = '0;
        exp_best = '0;
        exp_init = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start_round("r7");
        repeat (400) @(negedge clk);
        exp_last = 24'h000200;
        exp_best = 24'h000200;
        exp_init = 1'b0;
        push("r7_hit", D_HIT, cyc + 1);
        press_btn();

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", 64'(sbq.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
